// File: rtl/fft_output_serializer.sv
// Drain-side frame buffer for the 64-point FFT: collects eight 8-lane beats
// into a 64-sample frame, then streams the frame out one sample per cycle
// under valid/ready, optionally in bit-reversed read order.
`timescale 1ns/1ps
module fft_output_serializer #(
    parameter int DATA_WIDTH  = 32,
    parameter bit BIT_REVERSE = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] SET_0_IN,
    input  logic [DATA_WIDTH-1:0] SET_1_IN,
    input  logic [DATA_WIDTH-1:0] SET_2_IN,
    input  logic [DATA_WIDTH-1:0] SET_3_IN,
    input  logic [DATA_WIDTH-1:0] SET_4_IN,
    input  logic [DATA_WIDTH-1:0] SET_5_IN,
    input  logic [DATA_WIDTH-1:0] SET_6_IN,
    input  logic [DATA_WIDTH-1:0] SET_7_IN,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [5:0]            out_index,
    output logic                  out_last
);

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t          state_reg, state_next;
    logic [2:0]      beat_cnt_reg, beat_cnt_next;
    logic [5:0]      idx_reg, idx_next;
    logic            wr_en;
    logic [5:0]      idx_rev;
    logic [5:0]      rd_addr;

    logic [DATA_WIDTH-1:0] lane_in [8];
    logic [DATA_WIDTH-1:0] lane_rd [8];

    assign lane_in[0] = SET_0_IN;
    assign lane_in[1] = SET_1_IN;
    assign lane_in[2] = SET_2_IN;
    assign lane_in[3] = SET_3_IN;
    assign lane_in[4] = SET_4_IN;
    assign lane_in[5] = SET_5_IN;
    assign lane_in[6] = SET_6_IN;
    assign lane_in[7] = SET_7_IN;

    // Frame buffer split into one 8-deep bank per lane: address s*8+l lives
    // in bank l at row s, so a whole beat is written in a single cycle.
    // Read address bits [2:0] pick the bank, bits [5:3] pick the row.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_bank
            logic [DATA_WIDTH-1:0] bank_mem [8];

            // Lane write: one row per accepted beat; contents are never reset.
            always_ff @(posedge clk) begin
                if (wr_en) begin
                    bank_mem[beat_cnt_reg] <= lane_in[gi];
                end
            end

            assign lane_rd[gi] = bank_mem[rd_addr[5:3]];
        end
    endgenerate

    // Bit-reversed view of the drain index.
    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_bitrev
            assign idx_rev[gi] = idx_reg[5-gi];
        end
    endgenerate

    assign rd_addr = BIT_REVERSE ? idx_rev : idx_reg;

    // State and counter registers; reset drops any partial frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= FILL;
            beat_cnt_reg <= 3'd0;
            idx_reg      <= 6'd0;
        end else begin
            state_reg    <= state_next;
            beat_cnt_reg <= beat_cnt_next;
            idx_reg      <= idx_next;
        end
    end

    // Next-state logic and handshake outputs for the fill/drain phases.
    always_comb begin
        state_next    = state_reg;
        beat_cnt_next = beat_cnt_reg;
        idx_next      = idx_reg;
        wr_en         = 1'b0;
        in_ready      = 1'b0;
        out_valid     = 1'b0;
        case (state_reg)
            FILL: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    wr_en         = !rst;
                    beat_cnt_next = beat_cnt_reg + 3'd1;
                    if (beat_cnt_reg == 3'd7) begin
                        state_next = DRAIN;
                        idx_next   = 6'd0;
                    end
                end
            end
            DRAIN: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    idx_next = idx_reg + 6'd1;
                    if (idx_reg == 6'd63) begin
                        state_next = FILL;
                        idx_next   = 6'd0;
                    end
                end
            end
            default: begin
                state_next = FILL;
            end
        endcase
    end

    assign out_index = idx_reg;
    assign out_last  = out_valid && (idx_reg == 6'd63);
    assign out_data  = out_valid ? lane_rd[rd_addr[2:0]] : '0;

endmodule

// File: tb/tb_fft_output_serializer.sv
// Bench for fft_output_serializer: a natural-order and a bit-reversed
// instance share one stimulus stream and are checked against a frame model.
`timescale 1ns/1ps
module tb_fft_output_serializer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] set_in [8];

    logic        in_ready_n, in_ready_r;
    logic        out_valid_n, out_valid_r;
    logic        out_last_n, out_last_r;
    logic [5:0]  out_index_n, out_index_r;
    logic [31:0] out_data_n, out_data_r;

    int total  = 0;
    int passed = 0;

    // Reference frame: model[a] is the sample loaded at address a = s*8+l.
    logic [31:0] model [64];

    always #5 clk = ~clk;

    fft_output_serializer #(.DATA_WIDTH(32), .BIT_REVERSE(1'b0)) dut_nat (
        .clk(clk), .rst(rst),
        .SET_0_IN(set_in[0]), .SET_1_IN(set_in[1]), .SET_2_IN(set_in[2]), .SET_3_IN(set_in[3]),
        .SET_4_IN(set_in[4]), .SET_5_IN(set_in[5]), .SET_6_IN(set_in[6]), .SET_7_IN(set_in[7]),
        .in_valid(in_valid), .in_ready(in_ready_n),
        .out_data(out_data_n), .out_valid(out_valid_n), .out_ready(out_ready),
        .out_index(out_index_n), .out_last(out_last_n)
    );

    fft_output_serializer #(.DATA_WIDTH(32), .BIT_REVERSE(1'b1)) dut_rev (
        .clk(clk), .rst(rst),
        .SET_0_IN(set_in[0]), .SET_1_IN(set_in[1]), .SET_2_IN(set_in[2]), .SET_3_IN(set_in[3]),
        .SET_4_IN(set_in[4]), .SET_5_IN(set_in[5]), .SET_6_IN(set_in[6]), .SET_7_IN(set_in[7]),
        .in_valid(in_valid), .in_ready(in_ready_r),
        .out_data(out_data_r), .out_valid(out_valid_r), .out_ready(out_ready),
        .out_index(out_index_r), .out_last(out_last_r)
    );

    // Reverse the six low bits of k by peeling them off arithmetically.
    function automatic int bitrev6(input int k);
        int r = 0;
        int v = k;
        for (int b = 0; b < 6; b++) begin
            r = r * 2 + (v % 2);
            v = v / 2;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Everything an idle (filling) block must show on its outputs.
    task automatic idle_checks(input string where);
        chk({where, "_in_ready_nat"},  32'(in_ready_n),  32'd1);
        chk({where, "_in_ready_rev"},  32'(in_ready_r),  32'd1);
        chk({where, "_out_valid_nat"}, 32'(out_valid_n), 32'd0);
        chk({where, "_out_valid_rev"}, 32'(out_valid_r), 32'd0);
        chk({where, "_out_data_nat"},  out_data_n,       32'd0);
        chk({where, "_out_data_rev"},  out_data_r,       32'd0);
        chk({where, "_out_index_nat"}, 32'(out_index_n), 32'd0);
        chk({where, "_out_index_rev"}, 32'(out_index_r), 32'd0);
        chk({where, "_out_last_nat"},  32'(out_last_n),  32'd0);
        chk({where, "_out_last_rev"},  32'(out_last_r),  32'd0);
    endtask

    // Drive nbeats beats; mode 0 = lane value s*8+l, mode 1 = random data.
    task automatic load_frame(input int mode, input bit gaps, input int nbeats);
        for (int s = 0; s < nbeats; s++) begin
            if (gaps) begin
                int n = int'($urandom_range(0, 2));
                for (int g = 0; g < n; g++) begin
                    @(negedge clk);
                    idle_checks("gap");
                    in_valid = 1'b0;
                end
            end
            @(negedge clk);
            idle_checks("fill");
            for (int l = 0; l < 8; l++) begin
                logic [31:0] v;
                v = (mode == 0) ? 32'(s * 8 + l) : $urandom();
                set_in[l]        = v;
                model[s * 8 + l] = v;
            end
            in_valid = 1'b1;
            $display("beat %0d loaded (mode %0d)", s, mode);
        end
    endtask

    // Drain with out_ready pattern pat (0 = always 1, 1 = 1,0,0,1 repeating).
    // poke drives in_valid=1 with 0xDEAD lanes throughout the drain.
    // stop_at < 64 leaves the drain early while index stop_at is presented.
    task automatic drain(input int pat, input bit poke, input int stop_at);
        int k   = 0;
        int cyc = 0;
        bit rdy;
        while (k < 64 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            chk("drain_out_valid_nat", 32'(out_valid_n), 32'd1);
            chk("drain_out_valid_rev", 32'(out_valid_r), 32'd1);
            chk("drain_in_ready_nat",  32'(in_ready_n),  32'd0);
            chk("drain_in_ready_rev",  32'(in_ready_r),  32'd0);
            chk("drain_index_nat",     32'(out_index_n), 32'(k));
            chk("drain_index_rev",     32'(out_index_r), 32'(k));
            chk("drain_data_nat",      out_data_n,       model[k]);
            chk("drain_data_rev",      out_data_r,       model[bitrev6(k)]);
            chk("drain_last_nat",      32'(out_last_n),  32'(k == 63));
            chk("drain_last_rev",      32'(out_last_r),  32'(k == 63));
            in_valid = poke;
            if (poke) begin
                for (int l = 0; l < 8; l++) set_in[l] = 32'hDEAD;
            end
            if (k == stop_at) begin
                out_ready = 1'b0;
                break;
            end
            rdy = (pat == 0) ? 1'b1 : ((cyc % 4 == 1) || (cyc % 4 == 0));
            out_ready = rdy;
            if (rdy) begin
                $display("out k=%0d nat=0x%08h rev=0x%08h", k, out_data_n, out_data_r);
                k++;
            end
        end
        if (stop_at >= 64) begin
            chk("drain_handshakes", 32'(k), 32'd64);
            @(negedge clk);
            idle_checks("post_drain");
            in_valid  = 1'b0;
            out_ready = 1'b0;
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        for (int l = 0; l < 8; l++) set_in[l] = '0;

        // Reset held for two cycles.
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle_checks("reset");

        // Counting pattern: natural order and bit-reversed order.
        load_frame(0, 1'b0, 8);
        drain(0, 1'b0, 64);

        // Backpressure with out_ready 1,0,0,1.
        load_frame(1, 1'b0, 8);
        drain(1, 1'b0, 64);

        // Gaps between beats and 0xDEAD driven during drain, then a clean frame.
        load_frame(1, 1'b1, 8);
        drain(1, 1'b1, 64);
        load_frame(1, 1'b1, 8);
        drain(0, 1'b0, 64);

        // Reset after 5 beats, then a full new frame.
        load_frame(1, 1'b0, 5);
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle_checks("reset_fill");
        load_frame(1, 1'b0, 8);
        drain(0, 1'b0, 64);

        // Reset while index 30 is being presented, then a full new frame.
        load_frame(1, 1'b0, 8);
        drain(0, 1'b0, 30);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        idle_checks("reset_drain");
        rst = 1'b0;
        load_frame(1, 1'b1, 8);
        drain(1, 1'b0, 64);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fft_output_serializer.md
Name: fft_output_serializer

Overview:
- Drain-side counterpart of the 8-lane inter-stage register bank in the 64-point FFT datapath.
- Accepts eight parallel 32-bit complex samples per beat (16-bit real in [31:16], 16-bit imag in [15:0]).
- Buffers one 64-sample frame (8 beats), then streams it out one sample per cycle with a valid/ready handshake.
- Optionally applies bit-reversal to the read order so the FFT result leaves in natural order.

Parameters:
- DATA_WIDTH, 32, width of one complex sample; all SET_n_IN and out_data use it.
- BIT_REVERSE, 1, 1 = output k reads buffer address bitrev6(k); 0 = output k reads address k.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- SET_0_IN..SET_7_IN  input  DATA_WIDTH each  lane 0..7 of the current beat
- in_valid  input  1  beat on SET_n_IN is valid
- in_ready  output  1  block accepts a beat this cycle
- out_data  output  DATA_WIDTH  serialized sample
- out_valid  output  1  out_data valid
- out_ready  input  1  downstream accepts out_data
- out_index  output  6  natural-order index k of the current out_data
- out_last  output  1  high with out_valid when k = 63

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Storage: 64 x DATA_WIDTH buffer, not reset. Beat s (0..7), lane l is written to address s*8+l.
- States: FILL and DRAIN. Counters: beat_cnt[2:0], idx[5:0].
- Reset (rst=1 at a clock edge, in any state, including mid-fill or mid-drain):
  - state=FILL, beat_cnt=0, idx=0.
  - Partial frame is discarded.
  - Next cycle: in_ready=1, out_valid=0, out_last=0, out_index=0, out_data=0.
- FILL:
  - in_ready=1, out_valid=0.
  - On in_valid: write 8 lanes, beat_cnt++.
  - When in_valid is high with beat_cnt=7: go to DRAIN, set idx=0, beat_cnt wraps to 0.
  - in_valid=0 holds all state; gaps between beats are allowed.
- DRAIN:
  - in_ready=0; in_valid is ignored and no writes occur.
  - out_valid=1, out_index=idx.
  - out_data = buf[BIT_REVERSE ? bitrev6(idx) : idx], combinational read from the registered buffer.
  - bitrev6 reverses bits [5:0], e.g. bitrev6(1)=32, bitrev6(6)=24.
  - out_valid && out_ready: idx++.
  - Handshake at idx=63: return to FILL, idx=0; in_ready=1 the next cycle.
  - out_ready=0: out_data, out_index, and out_last are held stable (AXI-style; valid is never withdrawn).
- Latency:
  - Beat 7 accepted at edge N -> out_valid=1 with index 0 in cycle N+1.
  - Last output handshake at edge M -> in_ready=1 in cycle M+1.
  - Minimum frame period is 8 + 64 = 72 cycles with no overlap of fill and drain.
- Gating: out_data is forced to 0 whenever out_valid=0.
- out_last = out_valid && (idx==63).
- Width: no arithmetic on data; samples pass bit-exact.

Test Plan:
- Reset check: hold rst for 2 cycles, then release.
  - Required: in_ready=1, out_valid=0, out_data=0, out_index=0, out_last=0.
- Natural order (BIT_REVERSE=0): load 8 consecutive beats with lane value s*8+l; out_ready=1 throughout.
  - Required: out_valid rises the cycle after beat 7.
  - out_data = 0,1,...,63 on consecutive cycles; out_last only with 63; in_ready=1 the cycle after.
- Bit-reverse (BIT_REVERSE=1), same load.
  - Required sequence: 0x00, 0x20, 0x10, 0x30, 0x08, ...; out_index = 0,1,2,...; value at k=63 is 0x3F.
- Backpressure: drain with out_ready toggling 1,0,0,1 repeatedly.
  - Required: each sample held stable while out_ready=0; exactly 64 handshakes; no sample skipped or duplicated.
- Input gaps and ignored input: insert in_valid=0 gaps between beats, then drive in_valid=1 with 0xDEAD during DRAIN.
  - Required: gaps do not corrupt the frame; in_ready=0 during DRAIN; next frame unaffected by the 0xDEAD value.
- Reset mid-operation: assert rst after 5 beats, then load a full new frame.
  - Required: output is only the new frame's 64 samples.
  - Also assert rst at drain index 30: out_valid=0 next cycle and FILL is restarted.
